led_controller: RTL and testbench
=================================

Name: led_controller

Overview:
Bus-mapped output peripheral that drives the board LEDs from processor writes. It is the write-direction counterpart of the key input controller and sits on the same shared tri-state data bus. It holds a data register (the LED pattern) and a control/status register. The control/status register provides a blink mode with a hardware half-period counter and a sticky "pending" flag that records unacknowledged updates.

Parameters:
DBITS, 32, bus data/address width
MY_NAMESPACE, 32'hF000_0004, address of LED data register (read/write)
LCTRL_ADDR, 32'hF000_0104, address of control/status register (read/write)
NLEDS, 10, number of LED outputs
BLINK_DIV, 5_000_000, blink half-period in clk cycles (must be >= 2)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
dbus  inout  DBITS  shared data bus; driven only during reads of this block
address  input  DBITS  bus address
wrtEn  input  1  1 = write cycle, 0 = read cycle
leds  output  NLEDS  LED drive, 1 = lit

Behaviour:
- Decode:
  - selData = (address == MY_NAMESPACE).
  - selCtrl = (address == LCTRL_ADDR).
  - Writes are taken at posedge when sel && wrtEn.
  - Reads are combinational: while sel && !wrtEn, the block drives dbus in the same cycle.
- Bus drive:
  - Data read returns {zeros, ldata[NLEDS-1:0]}.
  - Ctrl read returns {zeros, pending, phase, blinkEn} in bits [2:0].
  - At all other times dbus = all Z. The block must never drive during a write or when not selected.
- State: ldata[NLEDS-1:0], blinkEn, phase, pending, cnt (width ceil(log2(BLINK_DIV))).
- Reset (sync, priority over everything): ldata=0, blinkEn=0, phase=1, pending=0, cnt=0. Consequently leds=0 in the cycle after reset is sampled. A reset asserted mid-blink aborts the count immediately.
- Data write:
  - ldata <= dbus[NLEDS-1:0]; upper bus bits are ignored.
  - pending <= 1. If pending was already 1, it stays 1; there is no overrun bit.
  - If blinkEn=1: cnt <= 0 and phase <= 1, so the new pattern is visible at once and held a full half-period.
- Ctrl write:
  - blinkEn <= dbus[0].
  - pending <= 0 only if dbus[2]==0; writing 1 to bit2 leaves pending unchanged.
  - Bit1 (phase) is read-only and ignored on write.
  - Any ctrl write sets cnt <= 0 and phase <= 1, whether blink is enabled or disabled.
- Blink counter:
  - Runs only when blinkEn=1 and there is no write to this block that cycle.
  - If cnt == BLINK_DIV-1: cnt <= 0 and phase <= ~phase. Otherwise cnt <= cnt+1.
  - Result: phase toggles every BLINK_DIV cycles, a 2*BLINK_DIV full period.
  - When blinkEn=0: cnt holds 0 and phase holds 1.
- Output (registered or combinational from state; either is acceptable):
  - leds = ldata when blinkEn=0.
  - leds = (phase ? ldata : 0) when blinkEn=1.
- Reads have no side effects. A read of either register changes no state.
- Address match with an unmapped neighbour (e.g. MY_NAMESPACE+4) has no effect and leaves dbus Z.

Test Plan:
1. Reset, then read MY_NAMESPACE and LCTRL_ADDR -> dbus = 0x00000000 and 0x00000002 (phase=1); leds=0; dbus Z when idle.
2. Write 0x3FF to MY_NAMESPACE -> next cycle leds=0x3FF; ctrl read = 0x6 (pending=1, phase=1). Write ctrl 0x0 -> ctrl read = 0x2. Write ctrl 0x4 with pending=1 -> pending stays 1.
3. With BLINK_DIV=4: write data 0x155, write ctrl 0x1 -> leds=0x155 for 4 cycles, 0 for 4 cycles, 0x155 again; ctrl read shows phase toggling.
4. In blink off-phase (leds=0), write data 0x0AA -> next cycle leds=0x0AA, phase=1, counter restarted (stays lit 4 cycles).
5. Assert reset for 1 cycle mid-blink -> leds=0, ctrl read 0x2, counter idle; no toggling afterwards.
6. Write 0xFFFF_FC01 to data -> ldata=0x001 (upper bits dropped). Write/read at 0xF000_0008 -> no state change, dbus Z.

Source files
------------

// File: rtl/led_controller.sv
// Bus-mapped LED driver: pattern register plus control/status (blink, phase, pending); writes land on posedge,
// reads drive dbus combinationally in the same cycle; no backpressure, every bus access completes in one cycle.
module led_controller #(
    parameter int          DBITS        = 32,
    parameter logic [31:0] MY_NAMESPACE = 32'hF000_0004,
    parameter logic [31:0] LCTRL_ADDR   = 32'hF000_0104,
    parameter int          NLEDS        = 10,
    parameter int          BLINK_DIV    = 5_000_000
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [DBITS-1:0] dbus,
    input  logic [DBITS-1:0] address,
    input  logic             wrtEn,
    output logic [NLEDS-1:0] leds
);

    localparam int             CW      = $clog2(BLINK_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(BLINK_DIV - 1);

    logic [NLEDS-1:0] ldata;
    logic             blinkEn;
    logic             phase;
    logic             pending;
    logic [CW-1:0]    cnt;

    logic             selData;
    logic             selCtrl;
    logic             rd_drive;
    logic [DBITS-1:0] rd_val;

    assign selData  = (address == DBITS'(MY_NAMESPACE));
    assign selCtrl  = (address == DBITS'(LCTRL_ADDR));
    assign rd_drive = (selData || selCtrl) && !wrtEn;

    always_comb begin
        rd_val = '0;
        if (selData)
            rd_val[NLEDS-1:0] = ldata;
        else if (selCtrl)
            rd_val[2:0] = {pending, phase, blinkEn};
    end

    assign dbus = rd_drive ? rd_val : 'z;

    // Upper data-bus bits are don't-care on writes.
    logic unused_dbus;
    assign unused_dbus = ^dbus[DBITS-1:NLEDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            ldata   <= '0;
            blinkEn <= 1'b0;
            phase   <= 1'b1;
            pending <= 1'b0;
            cnt     <= '0;
        end else if (selData && wrtEn) begin
            ldata   <= dbus[NLEDS-1:0];
            pending <= 1'b1;
            // Restart the half-period so a fresh pattern is shown immediately and held in full.
            if (blinkEn) begin
                cnt   <= '0;
                phase <= 1'b1;
            end
        end else if (selCtrl && wrtEn) begin
            blinkEn <= dbus[0];
            if (!dbus[2])
                pending <= 1'b0;
            cnt     <= '0;
            phase   <= 1'b1;
        end else if (blinkEn) begin
            if (cnt == CNT_MAX) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign leds = (!blinkEn || phase) ? ldata : '0;

endmodule

// File: tb/tb_led_controller.sv
// Directed bench for led_controller with a short blink divider; expectations queued at stimulus, popped at sample.
module tb_led_controller;

    localparam int          DBITS  = 32;
    localparam int          NLEDS  = 10;
    localparam int          BDIV   = 4;
    localparam logic [31:0] A_DATA = 32'hF000_0004;
    localparam logic [31:0] A_CTRL = 32'hF000_0104;
    localparam logic [31:0] A_NBR  = 32'hF000_0008;
    localparam logic [31:0] A_IDLE = 32'h0000_0000;
    localparam logic [31:0] FLOAT  = 32'hFFFF_FFFF;

    logic             clk = 1'b0;
    logic             reset;
    logic [DBITS-1:0] address;
    logic             wrtEn;
    logic [NLEDS-1:0] leds;
    logic             tb_drv;
    logic [DBITS-1:0] tb_dat;
    wire  [DBITS-1:0] dbus;

    // Weak pull-ups make an undriven bus read as all ones.
    for (genvar g = 0; g < DBITS; g++) begin : g_pu
        pullup (dbus[g]);
    end
    assign dbus = tb_drv ? tb_dat : 'z;

    led_controller #(
        .DBITS       (DBITS),
        .MY_NAMESPACE(A_DATA),
        .LCTRL_ADDR  (A_CTRL),
        .NLEDS       (NLEDS),
        .BLINK_DIV   (BDIV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .dbus   (dbus),
        .address(address),
        .wrtEn  (wrtEn),
        .leds   (leds)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic compare(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total_cnt++;
        assert (obs === e) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", t, obs, e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a;
        wrtEn   = 1'b1;
        tb_drv  = 1'b1;
        tb_dat  = d;
        @(negedge clk);
        wrtEn   = 1'b0;
        tb_drv  = 1'b0;
        address = A_IDLE;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string t);
        address = a;
        wrtEn   = 1'b0;
        exp_q.push_back(e);
        tag_q.push_back(t);
        #1;
        compare(dbus);
        address = A_IDLE;
    endtask

    task automatic chk_leds(input logic [31:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
        #1;
        compare({22'b0, leds});
    endtask

    initial begin
        logic [31:0] e;
        reset   = 1'b1;
        address = A_IDLE;
        wrtEn   = 1'b0;
        tb_drv  = 1'b0;
        tb_dat  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        rd(A_DATA, 32'h0, "rst_data");
        rd(A_CTRL, 32'h2, "rst_ctrl");
        chk_leds(32'h0, "rst_leds");
        rd(A_IDLE, FLOAT, "idle_z");

        // Data write, pending flag, acknowledge
        wr(A_DATA, 32'h3FF);
        chk_leds(32'h3FF, "wr_leds");
        rd(A_DATA, 32'h3FF, "wr_data");
        rd(A_CTRL, 32'h6, "pend_set");
        rd(A_CTRL, 32'h6, "read_no_side_effect");
        wr(A_CTRL, 32'h0);
        rd(A_CTRL, 32'h2, "pend_clr");
        wr(A_DATA, 32'h3FF);
        rd(A_CTRL, 32'h6, "pend_reset");
        wr(A_CTRL, 32'h4);
        rd(A_CTRL, 32'h6, "pend_keep_bit2");

        // Blink: lit 4, dark 4, lit 4, ...
        wr(A_DATA, 32'h155);
        wr(A_CTRL, 32'h1);
        for (int i = 0; i < 13; i++) begin
            e = (((i / BDIV) % 2) == 0) ? 32'h155 : 32'h0;
            chk_leds(e, $sformatf("blink_leds_%0d", i));
            rd(A_CTRL, (e != 0) ? 32'h3 : 32'h1, $sformatf("blink_ctrl_%0d", i));
            @(negedge clk);
        end
        chk_leds(32'h0, "off_phase");

        // Data write in the dark phase restarts the half-period
        wr(A_DATA, 32'h0AA);
        rd(A_CTRL, 32'h7, "restart_ctrl");
        for (int j = 0; j < 6; j++) begin
            chk_leds((j < BDIV) ? 32'h0AA : 32'h0, $sformatf("restart_leds_%0d", j));
            @(negedge clk);
        end

        // Reset mid-blink
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_leds(32'h0, "midrst_leds");
        rd(A_CTRL, 32'h2, "midrst_ctrl");
        rd(A_DATA, 32'h0, "midrst_data");
        wr(A_DATA, 32'h3C3);
        for (int k = 0; k < 10; k++) begin
            chk_leds(32'h3C3, $sformatf("noblink_%0d", k));
            @(negedge clk);
        end
        rd(A_CTRL, 32'h6, "noblink_ctrl");

        // Upper bits dropped; unmapped neighbour ignored
        wr(A_DATA, 32'hFFFF_FC01);
        rd(A_DATA, 32'h001, "trunc_data");
        chk_leds(32'h001, "trunc_leds");
        wr(A_NBR, 32'h3FF);
        rd(A_DATA, 32'h001, "nbr_data");
        rd(A_CTRL, 32'h6, "nbr_ctrl");
        rd(A_NBR, FLOAT, "nbr_z");
        chk_leds(32'h001, "nbr_leds");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
